// File: rtl/registro_etapa_param.sv
`default_nettype none
// ============================================================================
// Module      : registro_etapa_param
// Description : Parameterised pipeline stage register (write-back stage) with
//               a valid/ready handshake. It holds up to two entries: a main
//               register that drives the outputs and a skid register. The
//               outputs can optionally be re-registered on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module registro_etapa_param #(
  parameter int DATA_W     = 32,
  parameter int DIR_W      = 4,
  parameter int CTRL_W     = 1,
  parameter int HALF_CYCLE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_mem,
  input  logic [DIR_W-1:0]  in_dir,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_wr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_mem,
  output logic [DIR_W-1:0]  out_dir,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_wr,
  output logic [1:0]        ocupacion
);

  // Payload packed as {wr, ctrl, dir, mem, alu}
  localparam int PAY_W = 2 * DATA_W + DIR_W + CTRL_W + 1;

  // State encoding equals the number of held entries, so ocupacion is the state
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PAY_W-1:0] m_q, m_d;
  logic [PAY_W-1:0] s_q, s_d;
  logic [PAY_W-1:0] in_pay;
  logic             out_valid_w;
  logic [PAY_W-1:0] out_pay_w;
  logic             accept;
  logic             release_evt;

  assign in_pay      = {in_wr, in_ctrl, in_dir, in_mem, in_alu};
  // Ready depends only on registered state: no combinational path from out_ready
  assign in_ready    = (state_q != ST_TWO);
  assign accept      = in_valid & in_ready;
  // Release is judged on the valid the consumer actually sees
  assign release_evt = out_valid_w & out_ready;
  assign ocupacion   = state_q;

  // Next-state and data-path selection; flush overrides every other event
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            m_d     = in_pay;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && release_evt) begin
            m_d = in_pay;
          end else if (accept) begin
            s_d     = in_pay;
            state_d = ST_TWO;
          end else if (release_evt) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // Skid entry moves forward; no accept possible while full
          if (release_evt) begin
            m_d     = s_q;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Rising-edge state, main and skid registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

  generate
    if (HALF_CYCLE == 0) begin : g_direct
      assign out_valid_w = (state_q != ST_EMPTY);
      assign out_pay_w   = m_q;
    end else begin : g_half_cycle
      logic             ov_q, ov_d;
      logic [PAY_W-1:0] op_q, op_d;

      // Output copy always mirrors the main register and its valid bit
      always_comb begin
        ov_d = (state_q != ST_EMPTY);
        op_d = m_q;
      end

      // Falling-edge output stage, also cleared asynchronously
      always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ov_q <= 1'b0;
          op_q <= '0;
        end else begin
          ov_q <= ov_d;
          op_q <= op_d;
        end
      end

      assign out_valid_w = ov_q;
      assign out_pay_w   = op_q;
    end
  endgenerate

  assign out_valid = out_valid_w;
  assign out_alu   = out_pay_w[DATA_W-1:0];
  assign out_mem   = out_pay_w[2*DATA_W-1:DATA_W];
  assign out_dir   = out_pay_w[2*DATA_W+DIR_W-1:2*DATA_W];
  assign out_ctrl  = out_pay_w[2*DATA_W+DIR_W+CTRL_W-1:2*DATA_W+DIR_W];
  // A write enable is never presented on an invalid output
  assign out_wr    = out_pay_w[PAY_W-1] & out_valid_w;

endmodule
`default_nettype wire

// File: doc/registro_etapa_param.md
REGISTRO_ETAPA_PARAM -- requirements
Module: registro_etapa_param

Interface
REQ-001 Parameter DATA_W, default 32: width of each of the two data payload fields (ALU result, memory result).
REQ-002 Parameter DIR_W, default 4: width of the write-back register address field.
REQ-003 Parameter CTRL_W, default 1: width of the write-back select/control field.
REQ-004 Parameter HALF_CYCLE, default 0: 0 means outputs are driven straight from the posedge main register; 1 means outputs are re-registered on the falling edge of clk.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  in  1  sole clock; all state except the HALF_CYCLE output copy updates on the rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 in_valid  in  1  producer has a valid entry.
REQ-009 in_ready  out  1  block can accept an entry.
REQ-010 in_alu, in_mem  in  DATA_W each  payload.
REQ-011 in_dir  in  DIR_W; in_ctrl  in  CTRL_W; in_wr  in  1  register-file write enable.
REQ-012 flush  in  1  synchronous discard of all held entries.
REQ-013 out_valid  out  1; out_ready  in  1  consumer accepts.
REQ-014 out_alu, out_mem, out_dir, out_ctrl, out_wr  out  same widths as the corresponding inputs.
REQ-015 ocupacion  out  2  number of held entries (0..2).

Function
REQ-016 Storage: main register M (drives outputs) plus skid register S; states EMPTY, ONE (M valid), TWO (M and S valid).
REQ-017 accept = in_valid & in_ready; release = out_valid & out_ready, both sampled at the rising edge.
REQ-018 in_ready SHALL be (state != TWO) and depend only on registered state, never combinationally on out_ready.
REQ-019 EMPTY: accept -> ONE with M loaded from the inputs; otherwise stay in EMPTY.
REQ-020 ONE: accept and release -> ONE with M loaded from the inputs; accept only -> TWO with S loaded; release only -> EMPTY; neither -> hold.
REQ-021 TWO: release -> ONE with M loaded from S; otherwise hold; no accept is possible.
REQ-022 Ordering SHALL be strictly FIFO, and no entry may be duplicated or dropped except by flush.
REQ-023 Flush has priority over all other events: next state is EMPTY, and any accept or release in the same cycle is discarded and counts as not having occurred.
REQ-024 Latency, HALF_CYCLE=0: an entry accepted at edge k appears on out_* with out_valid=1 immediately after edge k.
REQ-025 Latency, HALF_CYCLE=1: the output stage copies M and its valid bit on the falling edge following edge k; out_valid and out_* change only on falling edges; release uses this out_valid.
REQ-026 out_wr SHALL equal the stored wr AND out_valid, so a write enable is never asserted on an invalid output.
REQ-027 When out_valid=0, out_alu, out_mem, out_dir and out_ctrl hold their last values, which are don't-care.
REQ-028 ocupacion: 0, 1 or 2 for EMPTY, ONE or TWO, updated on the rising edge regardless of HALF_CYCLE.
REQ-029 Payload widths pass through unaltered, with no truncation or extension.

Reset
REQ-030 While rst_n=0: state EMPTY, M, S and output stage cleared to 0, out_valid=0, out_wr=0, ocupacion=0, in_ready=1.
REQ-031 Inputs SHALL be ignored while rst_n=0; the first accept is possible at the first rising edge with rst_n=1.
REQ-032 Reset asserted mid-operation discards all held entries immediately, without waiting for a clock edge.

Verification
REQ-033 HALF_CYCLE=0, out_ready=1, one entry (alu=0x11, dir=3, wr=1) -> out_valid=1 with those values after the same edge, EMPTY after the next edge, ocupacion 1 then 0.
REQ-034 out_ready=0, push A then B -> ocupacion=2, in_ready=0; C held on in_valid is not taken; raising out_ready yields A, B, C in order on consecutive cycles.
REQ-035 State TWO with flush=1, in_valid=1, out_ready=1 in the same cycle -> next state EMPTY, out_valid=0, out_wr=0, and no entry is released or accepted.
REQ-036 Continuous in_valid=1 and out_ready=1 for 100 cycles with incrementing alu -> one transfer per cycle, ocupacion stays 1, no gaps or duplicates.
REQ-037 HALF_CYCLE=1, accept at edge k -> out_* change only at the falling edge after k, and the release at edge k+1 is followed by the next entry at the falling edge after k+1.
REQ-038 rst_n pulled low mid-cycle in state TWO -> out_valid and out_wr go to 0 with no clock edge, and ocupacion=0.
